mult_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 8x8 multiplier datapath between NUM_REQ requesters.
- Grants one requester at a time and captures its operands.
- Drives the multiplier's en/a/b handshake, waits for ack, and returns the 16-bit product with a per-requester done pulse.
- Sits between client blocks and the single multiplier instance.
- An ack timeout guards against a hung datapath.

---
 rtl/mult_rr_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter
// Round-robin arbiter and sequencer that shares one 8x8 multiplier between
// NUM_REQ client blocks. One operation is outstanding at a time: the winner's
// operands are captured at grant, issued to the multiplier with a single-cycle
// mul_en, and the product (or a timeout error) is returned with a one-cycle
// done pulse on the owner's bit.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous, active-low reset
//   req      : per-requester request level
//   a_flat   : operand A of requester i at [8i+7:8i]
//   b_flat   : operand B of requester i at [8i+7:8i]
//   gnt      : one-hot owner, held from grant until the done cycle
//   done     : one-hot, one-cycle completion pulse
//   result   : 16-bit product, valid while any done bit is high
//   err      : high with done when the multiplier never acknowledged
//   mul_en   : multiplier enable, one cycle per operation
//   mul_a    : multiplier operand A, stable from issue through response
//   mul_b    : multiplier operand B, stable from issue through response
//   mul_out  : multiplier product
//   mul_ack  : multiplier acknowledge, expected one cycle after mul_en
module mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   a_flat,
  input  logic [8*NUM_REQ-1:0]   b_flat,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [15:0]            result,
  output logic                   err,
  output logic                   mul_en,
  output logic [7:0]             mul_a,
  output logic [7:0]             mul_b,
  input  logic [15:0]            mul_out,
  input  logic                   mul_ack
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [PW-1:0]        ptr_r;
  logic [PW-1:0]        ptr_nxt_s;
  logic [7:0]           cnt_r;
  logic [7:0]           cnt_nxt_s;

  logic                 any_req_s;
  logic [PW-1:0]        win_s;
  logic                 tmo_s;

  logic [NUM_REQ-1:0]   gnt_nxt_s;
  logic [NUM_REQ-1:0]   done_nxt_s;
  logic [15:0]          result_nxt_s;
  logic                 err_nxt_s;
  logic                 mul_en_nxt_s;
  logic [7:0]           mul_a_nxt_s;
  logic [7:0]           mul_b_nxt_s;

  // Requester index base+off, wrapped into 0..NUM_REQ-1 (off < NUM_REQ).
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum_v;
    sum_v = int'(base) + off;
    if (sum_v >= NUM_REQ) begin
      sum_v = sum_v - NUM_REQ;
    end else begin
      sum_v = sum_v;
    end
    return PW'(sum_v);
  endfunction

  // The last WAIT cycle before the error completion is the one where the
  // counter would be incremented up to TIMEOUT.
  assign tmo_s = (cnt_r == 8'(TIMEOUT - 1));

  // Round-robin search: first set req bit at or after ptr, with wrap.
  always_comb begin
    any_req_s = 1'b0;
    win_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req_s && req[wrap_idx(ptr_r, i)]) begin
        any_req_s = 1'b1;
        win_s     = wrap_idx(ptr_r, i);
      end else begin
        win_s     = win_s;
      end
    end
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      cnt_r   <= 8'd0;
      gnt     <= '0;
      done    <= '0;
      result  <= 16'd0;
      err     <= 1'b0;
      mul_en  <= 1'b0;
      mul_a   <= 8'd0;
      mul_b   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
      gnt     <= gnt_nxt_s;
      done    <= done_nxt_s;
      result  <= result_nxt_s;
      err     <= err_nxt_s;
      mul_en  <= mul_en_nxt_s;
      mul_a   <= mul_a_nxt_s;
      mul_b   <= mul_b_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mul_ack || tmo_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and timeout counter.
  // Operands and result hold unless explicitly updated, so mul_a/mul_b stay
  // stable for the whole operation and result persists after done.
  always_comb begin
    gnt_nxt_s    = gnt;
    done_nxt_s   = '0;
    result_nxt_s = result;
    err_nxt_s    = err;
    mul_en_nxt_s = 1'b0;
    mul_a_nxt_s  = mul_a;
    mul_b_nxt_s  = mul_b;
    ptr_nxt_s    = ptr_r;
    cnt_nxt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          gnt_nxt_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
          mul_a_nxt_s  = a_flat[{win_s, 3'b000} +: 8];
          mul_b_nxt_s  = b_flat[{win_s, 3'b000} +: 8];
          mul_en_nxt_s = 1'b1;
          if (win_s == PW'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
          end else begin
            ptr_nxt_s = win_s + 1'b1;
          end
        end else begin
          gnt_nxt_s = '0;
        end
      end
      ST_ISSUE: begin
        cnt_nxt_s = 8'd0;
      end
      ST_WAIT: begin
        if (mul_ack) begin
          result_nxt_s = mul_out;
          err_nxt_s    = 1'b0;
          done_nxt_s   = gnt;
        end else if (tmo_s) begin
          result_nxt_s = 16'd0;
          err_nxt_s    = 1'b1;
          done_nxt_s   = gnt;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      ST_RESP: begin
        gnt_nxt_s = '0;
        err_nxt_s = 1'b0;
      end
      default: begin
        gnt_nxt_s = '0;
        err_nxt_s = 1'b0;
      end
    endcase
  end

endmodule
